// File: rtl/barrel_rot_pipe.sv
// Pipelined WIDTH-bit shift/rotate unit: one binary-weighted shift step per stage,
// valid/ready on both sides, one op per cycle throughput.
module barrel_rot_pipe #(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [SHW-1:0]   in_amt,
  input  logic [2:0]       in_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_zero
);

  localparam logic [2:0] OP_ROR = 3'b000;
  localparam logic [2:0] OP_ROL = 3'b001;
  localparam logic [2:0] OP_LSR = 3'b010;
  localparam logic [2:0] OP_LSL = 3'b011;
  localparam logic [2:0] OP_ASR = 3'b100;

  // One power-of-two step; composing the steps selected by amt gives the full shift.
  function automatic logic [WIDTH-1:0] shift_step(input logic [WIDTH-1:0] d,
                                                  input logic [2:0]       op,
                                                  input int               s);
    logic signed [WIDTH-1:0] sd;
    sd = d;
    case (op)
      OP_ROR:  shift_step = (d >> s) | (d << (WIDTH - s));
      OP_ROL:  shift_step = (d << s) | (d >> (WIDTH - s));
      OP_LSR:  shift_step = d >> s;
      OP_LSL:  shift_step = d << s;
      OP_ASR:  shift_step = sd >>> s;
      default: shift_step = d;
    endcase
  endfunction

  logic [WIDTH-1:0] r_data [SHW];
  logic [SHW-1:0]   r_amt  [SHW];
  logic [2:0]       r_op   [SHW];
  logic [SHW-1:0]   r_vld;
  logic             r_zero;

  logic [WIDTH-1:0] w_src_data [SHW];
  logic [WIDTH-1:0] w_nxt_data [SHW];
  logic [SHW-1:0]   w_src_amt  [SHW];
  logic [2:0]       w_src_op   [SHW];
  logic [SHW-1:0]   w_src_vld;
  logic [SHW-1:0]   w_adv;
  logic             w_accept;

  assign in_ready = !rst && w_adv[0];
  assign w_accept = in_valid && in_ready;

  // Stage k loads from stage k-1 (stage 0 from the input port) and applies step 2^k.
  always_comb begin : stage_src
    w_src_data[0] = in_data;
    w_src_amt[0]  = in_amt;
    w_src_op[0]   = in_op;
    w_src_vld[0]  = w_accept;
    for (int k = 1; k < SHW; k++) begin
      w_src_data[k] = r_data[k-1];
      w_src_amt[k]  = r_amt[k-1];
      w_src_op[k]   = r_op[k-1];
      w_src_vld[k]  = r_vld[k-1];
    end
    for (int k = 0; k < SHW; k++) begin
      w_nxt_data[k] = w_src_amt[k][k] ? shift_step(w_src_data[k], w_src_op[k], 1 << k)
                                      : w_src_data[k];
    end
  end

  // A stage may load unless it and every stage downstream of it is full while the
  // consumer stalls; written flat so no stage's enable depends on another's.
  always_comb begin : stage_adv
    logic all_full;
    all_full = 1'b1;
    w_adv    = '0;
    for (int k = SHW - 1; k >= 0; k--) begin
      all_full = all_full && r_vld[k];
      w_adv[k] = out_ready || !all_full;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_vld <= '0;
    end else begin
      for (int k = 0; k < SHW; k++) begin
        if (w_adv[k]) r_vld[k] <= w_src_vld[k];
      end
    end
  end

  // Payload moves only with a valid op; the output stage is also cleared by reset.
  always_ff @(posedge clk) begin
    for (int k = 0; k < SHW; k++) begin
      if (w_adv[k] && w_src_vld[k]) begin
        r_data[k] <= w_nxt_data[k];
        r_amt[k]  <= w_src_amt[k];
        r_op[k]   <= w_src_op[k];
      end
    end
    if (w_adv[SHW-1] && w_src_vld[SHW-1]) begin
      r_zero <= (w_nxt_data[SHW-1] == '0);
    end
    if (rst) begin
      r_data[SHW-1] <= '0;
      r_zero        <= 1'b0;
    end
  end

  assign out_valid = r_vld[SHW-1];
  assign out_data  = r_data[SHW-1];
  assign out_zero  = r_zero;

endmodule

// File: tb/tb_barrel_rot_pipe.sv
// Scoreboard bench for barrel_rot_pipe: directed vectors, backpressure, random traffic
// and reset flush, with expected results queued at input accept and popped at output.
module tb_barrel_rot_pipe;
  localparam int WIDTH = 32;
  localparam int SHW   = 5;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic [SHW-1:0]   in_amt;
  logic [2:0]       in_op;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_zero;

  always #5 clk = ~clk;

  barrel_rot_pipe #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_amt    (in_amt),
    .in_op     (in_op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_zero  (out_zero)
  );

  int          n_tests = 0;
  int          n_fail  = 0;
  int          n_out   = 0;
  logic [31:0] sb [$];
  logic [31:0] drv_exp;

  function automatic logic [31:0] model(input logic [31:0] d, input logic [4:0] a,
                                        input logic [2:0] op);
    logic signed [31:0] sd;
    int s;
    s  = int'(a);
    sd = d;
    case (op)
      3'd0:    model = (a == 0) ? d : ((d >> s) | (d << (32 - s)));
      3'd1:    model = (a == 0) ? d : ((d << s) | (d >> (32 - s)));
      3'd2:    model = d >> s;
      3'd3:    model = d << s;
      3'd4:    model = sd >>> s;
      default: model = d;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic monitor();
    logic        stall_prev;
    logic [31:0] stall_data;
    logic [31:0] exp;
    stall_prev = 1'b0;
    stall_data = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        sb.delete();
        stall_prev = 1'b0;
      end else begin
        if (stall_prev) begin
          check("stall_valid", 32'(out_valid), 32'd1);
          check("stall_hold", out_data, stall_data);
        end
        if (out_valid && out_ready) begin
          check("sb_nonempty", 32'(sb.size() != 0), 32'd1);
          if (sb.size() != 0) begin
            exp = sb.pop_front();
            check("out_data", out_data, exp);
            check("out_zero", 32'(out_zero), 32'(exp == 32'd0));
            n_out++;
          end
        end
        stall_prev = out_valid && !out_ready;
        stall_data = out_data;
        if (in_valid && in_ready) sb.push_back(drv_exp);
      end
    end
  endtask

  task automatic drive_op(input logic [31:0] d, input logic [4:0] a, input logic [2:0] op,
                          input logic [31:0] exp);
    int t;
    in_data  = d;
    in_amt   = a;
    in_op    = op;
    drv_exp  = exp;
    in_valid = 1'b1;
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!in_ready && t < 100);
    check("accept", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic timed_op(input logic [31:0] d, input logic [4:0] a, input logic [2:0] op,
                          input logic [31:0] exp);
    int lat;
    drive_op(d, a, op, exp);
    lat = 1;
    while (!out_valid && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check("latency", 32'(lat), 32'd5);
  endtask

  task automatic drain();
    int t;
    out_ready = 1'b1;
    in_valid  = 1'b0;
    t = 0;
    do begin
      @(negedge clk);
      #1;
      t++;
    end while ((sb.size() != 0 || out_valid) && t < 100);
    check("drain_empty", 32'(sb.size()), 32'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int acc;
    int cyc;
    int n0;
    logic [31:0] d;
    logic [4:0]  a;
    logic [2:0]  op;

    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    in_amt    = '0;
    in_op     = '0;
    out_ready = 1'b0;
    drv_exp   = '0;
    fork
      monitor();
    join_none

    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", out_data, 32'd0);
    check("rst_out_zero", 32'(out_zero), 32'd0);
    rst       = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    check("idle_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;

    timed_op(32'h8000_0001, 5'd1, 3'd0, 32'hC000_0000);
    drain();
    timed_op(32'h8000_0001, 5'd4, 3'd1, 32'h0000_0018);
    drain();

    drive_op(32'h8000_0000, 5'd31, 3'd4, 32'hFFFF_FFFF);
    drive_op(32'h8000_0000, 5'd31, 3'd2, 32'h0000_0001);
    drive_op(32'h0000_0001, 5'd31, 3'd3, 32'h8000_0000);
    drain();

    for (int i = 0; i < 8; i++) drive_op(32'hDEAD_BEEF, 5'd0, 3'(i), 32'hDEAD_BEEF);
    drive_op(32'hDEAD_BEEF, 5'd7, 3'd5, 32'hDEAD_BEEF);
    drive_op(32'h0000_0001, 5'd1, 3'd2, 32'h0000_0000);
    drain();

    // Backpressure: fill the pipe with the consumer stalled, then release.
    out_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      d  = 32'h0101_0000 * 32'(i + 1) + 32'h80;
      a  = 5'(i * 3 + 1);
      op = 3'(i % 5);
      in_data  = d;
      in_amt   = a;
      in_op    = op;
      drv_exp  = model(d, a, op);
      in_valid = 1'b1;
      @(negedge clk);
      check("fill_in_ready", 32'(in_ready), 32'(i < 5));
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    for (int j = 0; j < 5; j++) begin
      @(negedge clk);
      check("release_rate", 32'(out_valid), 32'd1);
      @(posedge clk);
      #1;
      if (j == 0) in_valid = 1'b0;
    end
    drain();

    // Random traffic against the reference model.
    n0  = n_out;
    acc = 0;
    cyc = 0;
    while (acc < 10000 && cyc < 60000) begin
      d  = ($urandom_range(0, 7) == 0) ? 32'($urandom_range(0, 3)) : 32'($urandom);
      a  = 5'($urandom_range(0, 31));
      op = 3'($urandom_range(0, 7));
      in_data   = d;
      in_amt    = a;
      in_op     = op;
      drv_exp   = model(d, a, op);
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      if (in_valid && in_ready) acc++;
      @(posedge clk);
      #1;
      cyc++;
    end
    check("rand_accepted", 32'(acc), 32'd10000);
    drain();
    check("rand_count", 32'(n_out - n0), 32'(acc));

    // Reset with ops in flight: none of them may emerge afterwards.
    out_ready = 1'b1;
    drive_op(32'h1234_5678, 5'd3, 3'd0, model(32'h1234_5678, 5'd3, 3'd0));
    drive_op(32'h0F0F_0F0F, 5'd9, 3'd1, model(32'h0F0F_0F0F, 5'd9, 3'd1));
    drive_op(32'hF000_0000, 5'd2, 3'd4, model(32'hF000_0000, 5'd2, 3'd4));
    rst       = 1'b1;
    out_ready = 1'b0;
    @(negedge clk);
    check("rst_flush_in_ready", 32'(in_ready), 32'd0);
    @(posedge clk);
    #1;
    check("rst_flush_valid", 32'(out_valid), 32'd0);
    check("rst_flush_data", out_data, 32'd0);
    rst       = 1'b0;
    out_ready = 1'b1;
    n0 = n_out;
    drive_op(32'hCAFE_F00D, 5'd8, 3'd3, 32'hFEF0_0D00);
    drive_op(32'h0000_00F0, 5'd4, 3'd2, 32'h0000_000F);
    drain();
    check("post_rst_count", 32'(n_out - n0), 32'd2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
